// File: rtl/seleccion_frecuencia.sv
// seleccion_frecuencia: operator frequency selector.
// Two raw push buttons ([1] = up, [0] = down) step a 6-bit setpoint between
// F_MIN and F_MAX. The setpoint is presented in binary (f) and as two packed
// BCD digits (f_deco, [7:4] tens, [3:0] units) for the display driver.
// Each button passes through a 2-flop synchronizer, a debouncer and a
// rising-edge detector, so a press gives exactly one step however long it is held.
// Optional build macro SELFREC_WRAP_EN: when defined, stepping past a limit
// wraps to the opposite limit instead of saturating.
module seleccion_frecuencia #(
  parameter int DEB_CYCLES = 1000000,
  parameter int F_MIN      = 1,
  parameter int F_MAX      = 50,
  parameter int F_RST      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ENf,
  input  logic [1:0] botones,
  output logic [5:0] f,
  output logic [7:0] f_deco
);

  // Counter only has to reach DEB_CYCLES-1.
  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

  localparam logic [5:0] F_MIN_V = 6'(F_MIN);
  localparam logic [5:0] F_MAX_V = 6'(F_MAX);
  localparam logic [5:0] F_RST_V = 6'(F_RST);
  localparam logic [7:0] F_RST_BCD = {4'(F_RST / 10), 4'(F_RST % 10)};

  localparam int BTN_INC = 1;
  localparam int BTN_DEC = 0;

  // Input conditioning state, one lane per button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            deb_prev_q;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Setpoint state.
  logic [5:0] f_q, f_d;
  logic [7:0] f_deco_q, f_deco_d;

  logic       inc_p, dec_p;
  logic [2:0] tens_d;
  logic [5:0] tens_x10_d;
  logic [5:0] units_full_d;

  // Two-flop synchronizer for the asynchronous button pads.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= botones;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the counter only runs while the synchronized level disagrees
  // with the accepted level; any bounce back to agreement restarts it.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounce counters, accepted levels and the edge-detector history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
    end else begin
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  // One-cycle pulses on the rising edge of each accepted level.
  always_comb begin
    inc_p = deb_q[BTN_INC] & ~deb_prev_q[BTN_INC];
    dec_p = deb_q[BTN_DEC] & ~deb_prev_q[BTN_DEC];
  end

  // Next setpoint; pulses arriving while ENf is low are simply dropped.
  always_comb begin
    f_d = f_q;
    if (ENf) begin
      if (inc_p && !dec_p) begin
        if (f_q < F_MAX_V) begin
          f_d = f_q + 6'd1;
        end else begin
`ifdef SELFREC_WRAP_EN
          f_d = F_MIN_V;
`else
          f_d = f_q;
`endif
        end
      end else if (dec_p && !inc_p) begin
        if (f_q > F_MIN_V) begin
          f_d = f_q - 6'd1;
        end else begin
`ifdef SELFREC_WRAP_EN
          f_d = F_MAX_V;
`else
          f_d = f_q;
`endif
        end
      end
    end
  end

  // Binary to BCD of the next setpoint by range compare (max 63, so tens <= 6).
  always_comb begin
    tens_d     = 3'd0;
    tens_x10_d = 6'd0;
    if (f_d >= 6'd60) begin
      tens_d     = 3'd6;
      tens_x10_d = 6'd60;
    end else if (f_d >= 6'd50) begin
      tens_d     = 3'd5;
      tens_x10_d = 6'd50;
    end else if (f_d >= 6'd40) begin
      tens_d     = 3'd4;
      tens_x10_d = 6'd40;
    end else if (f_d >= 6'd30) begin
      tens_d     = 3'd3;
      tens_x10_d = 6'd30;
    end else if (f_d >= 6'd20) begin
      tens_d     = 3'd2;
      tens_x10_d = 6'd20;
    end else if (f_d >= 6'd10) begin
      tens_d     = 3'd1;
      tens_x10_d = 6'd10;
    end
    units_full_d = f_d - tens_x10_d;
    f_deco_d     = {1'b0, tens_d, units_full_d[3:0]};
  end

  // Setpoint and its BCD image share one register stage so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q      <= F_RST_V;
      f_deco_q <= F_RST_BCD;
    end else begin
      f_q      <= f_d;
      f_deco_q <= f_deco_d;
    end
  end

  assign f      = f_q;
  assign f_deco = f_deco_q;

endmodule

// File: tb/tb_seleccion_frecuencia.sv
// Self-checking bench for seleccion_frecuencia with a short debounce time.
// Reference: a press held long enough moves the setpoint by one step
// (saturating or wrapping at the limits), exactly DEB+3 cycles after the
// raw edge; short glitches and presses with ENf low change nothing.
module tb_seleccion_frecuencia;

  localparam int DEB  = 4;
  localparam int FMIN = 1;
  localparam int FMAX = 50;
  localparam int FRST = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ENf;
  logic [1:0] botones;
  logic [5:0] f;
  logic [7:0] f_deco;

  int tests = 0;
  int fails = 0;
  int exp_f = FRST;

  always #5 clk = ~clk;

  seleccion_frecuencia #(
    .DEB_CYCLES(DEB),
    .F_MIN(FMIN),
    .F_MAX(FMAX),
    .F_RST(FRST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ENf(ENf),
    .botones(botones),
    .f(f),
    .f_deco(f_deco)
  );

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int model_step(input int cur, input logic [1:0] b, input logic en);
    if (!en) return cur;
    if (b == 2'b10) begin
      if (cur < FMAX) return cur + 1;
`ifdef SELFREC_WRAP_EN
      return FMIN;
`else
      return cur;
`endif
    end
    if (b == 2'b01) begin
      if (cur > FMIN) return cur - 1;
`ifdef SELFREC_WRAP_EN
      return FMAX;
`else
      return cur;
`endif
    end
    return cur;
  endfunction

  // Clean press held 'hold' cycles, then released; checks every cycle.
  task automatic press(input logic [1:0] b, input int hold, input string tag);
    int old_v, new_v, want;
    old_v = exp_f;
    new_v = model_step(exp_f, b, ENf);
    @(negedge clk);
    botones = b;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      want = (k < DEB + 3) ? old_v : new_v;
      tests++;
      if (f !== 6'(want) || f_deco !== bcd(want)) begin
        fails++;
        $display("FAIL %s cyc=%0d f=%0d f_deco=%h expected f=%0d f_deco=%h",
                 tag, k, f, f_deco, want, bcd(want));
      end
    end
    botones = 2'b00;
    for (int k = 1; k <= DEB + 6; k++) begin
      @(negedge clk);
      tests++;
      if (f !== 6'(new_v) || f_deco !== bcd(new_v)) begin
        fails++;
        $display("FAIL %s_release cyc=%0d f=%0d f_deco=%h expected f=%0d f_deco=%h",
                 tag, k, f, f_deco, new_v, bcd(new_v));
      end
    end
    exp_f = new_v;
  endtask

  // Short pulse of length len (< DEB) must be filtered out.
  task automatic glitch(input logic [1:0] b, input int len, input string tag);
    @(negedge clk);
    botones = b;
    repeat (len) @(negedge clk);
    botones = 2'b00;
    for (int k = 1; k <= DEB + 6; k++) begin
      @(negedge clk);
      tests++;
      if (f !== 6'(exp_f) || f_deco !== bcd(exp_f)) begin
        fails++;
        $display("FAIL %s cyc=%0d f=%0d f_deco=%h expected f=%0d", tag, k, f, f_deco, exp_f);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    botones = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_f = FRST;
  endtask

  task automatic test_reset();
    ENf = 1'b1;
    botones = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (f !== 6'(FRST) || f_deco !== 8'h01) begin
      fails++;
      $display("FAIL reset_value f=%0d f_deco=%h expected f=%0d f_deco=01", f, f_deco, FRST);
    end
    for (int k = 0; k < 24; k++) begin
      botones = (k % 3 == 0) ? 2'b00 : 2'b10;
      @(negedge clk);
      tests++;
      if (f !== 6'(FRST)) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d f=%0d expected %0d", k, f, FRST);
      end
    end
    botones = 2'b00;
    rst = 1'b0;
    exp_f = FRST;
    for (int k = 0; k < DEB + 6; k++) begin
      @(negedge clk);
      tests++;
      if (f !== 6'(FRST)) begin
        fails++;
        $display("FAIL reset_release cyc=%0d f=%0d expected %0d", k, f, FRST);
      end
    end
  endtask

  task automatic test_single_press();
    ENf = 1'b1;
    press(2'b10, 50, "single_press");
  endtask

  task automatic test_min_limit();
    do_reset();
    ENf = 1'b1;
    press(2'b10, DEB + 5, "min_up");
    press(2'b01, DEB + 5, "min_dn1");
    press(2'b01, DEB + 5, "min_dn2");
    tests++;
`ifdef SELFREC_WRAP_EN
    if (f !== 6'd50 || f_deco !== 8'h50) begin
      fails++;
      $display("FAIL min_wrap f=%0d f_deco=%h expected 50/50", f, f_deco);
    end
`else
    if (f !== 6'd1 || f_deco !== 8'h01) begin
      fails++;
      $display("FAIL min_sat f=%0d f_deco=%h expected 1/01", f, f_deco);
    end
`endif
  endtask

  task automatic test_max_limit();
    do_reset();
    ENf = 1'b1;
    for (int i = 0; i < 49; i++) press(2'b10, DEB + 4, "max_climb");
    tests++;
    if (f !== 6'd50 || f_deco !== 8'h50) begin
      fails++;
      $display("FAIL max_reach f=%0d f_deco=%h expected 50/50", f, f_deco);
    end
    press(2'b10, DEB + 4, "max_over");
    tests++;
`ifdef SELFREC_WRAP_EN
    if (f !== 6'd1 || f_deco !== 8'h01) begin
      fails++;
      $display("FAIL max_wrap f=%0d f_deco=%h expected 1/01", f, f_deco);
    end
`else
    if (f !== 6'd50 || f_deco !== 8'h50) begin
      fails++;
      $display("FAIL max_sat f=%0d f_deco=%h expected 50/50", f, f_deco);
    end
`endif
  endtask

  task automatic test_glitch();
    do_reset();
    ENf = 1'b1;
    press(2'b10, DEB + 4, "glitch_setup");
    glitch(2'b10, 2, "glitch_inc2");
    glitch(2'b01, DEB - 1, "glitch_dec");
    press(2'b11, DEB + 8, "both_pressed");
  endtask

  task automatic test_enable();
    do_reset();
    ENf = 1'b0;
    @(negedge clk);
    botones = 2'b10;
    for (int k = 1; k <= DEB + 10; k++) begin
      @(negedge clk);
      tests++;
      if (f !== 6'(exp_f)) begin
        fails++;
        $display("FAIL en_off cyc=%0d f=%0d expected %0d", k, f, exp_f);
      end
    end
    ENf = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests++;
      if (f !== 6'(exp_f)) begin
        fails++;
        $display("FAIL en_rise_held cyc=%0d f=%0d expected %0d", k, f, exp_f);
      end
    end
    botones = 2'b00;
    repeat (DEB + 6) @(negedge clk);
    ENf = 1'b0;
    press(2'b01, DEB + 6, "en_off_dec");
    ENf = 1'b1;
    for (int i = 0; i < 8; i++) press(2'b10, DEB + 4, "to_nine");
    tests++;
    if (f !== 6'd9 || f_deco !== 8'h09) begin
      fails++;
      $display("FAIL nine f=%0d f_deco=%h expected 9/09", f, f_deco);
    end
    press(2'b10, DEB + 4, "nine_to_ten");
    tests++;
    if (f !== 6'd10 || f_deco !== 8'h10) begin
      fails++;
      $display("FAIL ten f=%0d f_deco=%h expected 10/10", f, f_deco);
    end
  endtask

  task automatic test_reset_mid();
    ENf = 1'b1;
    press(2'b10, DEB + 4, "rmid_setup");
    // Reset just after the debounced level rises: the pending pulse must vanish.
    @(negedge clk);
    botones = 2'b10;
    repeat (DEB + 2) @(negedge clk);
    rst = 1'b1;
    botones = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_f = FRST;
    for (int k = 1; k <= DEB + 8; k++) begin
      @(negedge clk);
      tests++;
      if (f !== 6'(FRST) || f_deco !== bcd(FRST)) begin
        fails++;
        $display("FAIL reset_mid cyc=%0d f=%0d f_deco=%h expected %0d", k, f, f_deco, FRST);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] b;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      b   = 2'($urandom_range(0, 3));
      ENf = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0)
        glitch(b, $urandom_range(1, DEB - 1), "rand_glitch");
      else
        press(b, DEB + 4 + $urandom_range(0, 6), "rand_press");
    end
    ENf = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ENf = 1'b1;
    botones = 2'b00;
    test_reset();
    test_single_press();
    test_min_limit();
    test_max_limit();
    test_glitch();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
